// File: rtl/seq_det_ctrl_if.sv
// Bundle of control, configuration, serial-stream and status signals for seq_det_ctrl.
interface seq_det_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               in_valid;
  logic               in;
  logic               busy;
  logic               done;
  logic               hit;
  logic [CNT_W-1:0]   hit_count;
  logic               cfg_err;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, in_valid, in,
    input  busy, done, hit, hit_count, cfg_err
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, in_valid, in,
    output busy, done, hit, hit_count, cfg_err
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector: counts pattern hits in a qualified bit
// stream and ends the session with a one-cycle done when the target is reached.
module seq_det_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  seq_det_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic [CNT_W-1:0]   cnt_n;
  logic               match;
  logic               cfg_legal;

  // Next shift-register contents and match detection for the current bit
  always_comb begin
    hist_n    = {hist[MAX_LEN-2:0], bus.in};
    fill_n    = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask      = MAX_LEN'((32'd1 << len_q) - 32'd1);
    match     = (fill_n >= len_q) && ((hist_n & mask) == (pat_q & mask));
    cnt_n     = bus.hit_count + CNT_W'(1);
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN)) &&
                (bus.cfg_target != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hist          <= '0;
      fill          <= '0;
      pat_q         <= '0;
      len_q         <= '0;
      overlap_q     <= 1'b0;
      target_q      <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.hit       <= 1'b0;
      bus.hit_count <= '0;
      bus.cfg_err   <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.hit     <= 1'b0;
      bus.cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_legal) begin
              pat_q         <= bus.cfg_pattern;
              len_q         <= bus.cfg_len;
              overlap_q     <= bus.cfg_overlap;
              target_q      <= bus.cfg_target;
              hist          <= '0;
              fill          <= '0;
              bus.hit_count <= '0;
              bus.busy      <= 1'b1;
              state         <= RUN;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.in_valid) begin
            hist <= hist_n;
            if (match) begin
              bus.hit       <= 1'b1;
              bus.hit_count <= cnt_n;
              // Non-overlap: consumed bits must not contribute to the next match
              fill          <= overlap_q ? fill_n : '0;
              if (cnt_n == target_q) begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= DONE;
              end
            end else begin
              fill <= fill_n;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized scoreboard bench for seq_det_ctrl against a queue-based reference model.
module tb_seq_det_ctrl;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  typedef struct {
    logic             busy;
    logic             done;
    logic             hit;
    logic             cfg_err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  // Reference model: session phase, received bits since last clear, latched config
  int                 m_phase = 0;
  bit                 m_bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ov;
  int                 m_target;
  int                 m_count = 0;
  bit                 m_busy = 0;

  task automatic model_step();
    exp_t e;
    bit   ok;
    int   n;
    e.done = 0; e.hit = 0; e.cfg_err = 0;
    if (rst) begin
      m_phase = 0; m_busy = 0; m_count = 0; m_bits.delete();
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          if (bus.cfg_len >= 1 && int'(bus.cfg_len) <= MAX_LEN && bus.cfg_target != 0) begin
            m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ov = bus.cfg_overlap;
            m_target = int'(bus.cfg_target); m_count = 0; m_bits.delete();
            m_phase = 1; m_busy = 1;
          end else e.cfg_err = 1;
        end
        1: if (bus.abort) begin
          m_phase = 0; m_busy = 0;
        end else if (bus.in_valid) begin
          m_bits.push_back(bus.in);
          if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
          n  = m_bits.size();
          ok = (n >= m_len);
          for (int i = 0; i < m_len && ok; i++)
            if (m_bits[n - m_len + i] != m_pat[m_len - 1 - i]) ok = 0;
          if (ok) begin
            e.hit = 1; m_count++;
            if (!m_ov) m_bits.delete();
            if (m_count == m_target) begin
              m_phase = 2; m_busy = 0; e.done = 1;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
    e.busy = m_busy;
    e.cnt  = CNT_W'(m_count);
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic s, input logic a, input logic v, input logic b);
    rst = r; bus.start = s; bus.abort = a; bus.in_valid = v; bus.in = b;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic setcfg(input logic [MAX_LEN-1:0] p, input int l, input logic ov, input int t);
    bus.cfg_pattern = p; bus.cfg_len = LEN_W'(l); bus.cfg_overlap = ov; bus.cfg_target = CNT_W'(t);
  endtask

  task automatic stream(input logic [15:0] bits, input int n, input bit gapped);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      cyc(0, 0, 0, 1, v[i]);
      if (gapped) cyc(0, 0, 0, 0, 1);
    end
  endtask

  // Monitor: compare every registered output sample against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      nvec++;
      if (bus.busy !== e.busy || bus.done !== e.done || bus.hit !== e.hit ||
          bus.cfg_err !== e.cfg_err || bus.hit_count !== e.cnt) begin
        nmis++;
        $display("FAIL outputs @%0t: got busy=%b done=%b hit=%b cfg_err=%b cnt=%0d, exp busy=%b done=%b hit=%b cfg_err=%b cnt=%0d",
                 $time, bus.busy, bus.done, bus.hit, bus.cfg_err, bus.hit_count,
                 e.busy, e.done, e.hit, e.cfg_err, e.cnt);
      end
    end
  end

  initial begin
    int r;
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0; rst = 1;
    setcfg('0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // Non-overlap, one hit in 1011011, then abort
    setcfg(8'b1011, 4, 0, 3);
    cyc(0, 1, 0, 0, 0);
    stream(16'b1011011, 7, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // Overlap, two hits end the session
    setcfg(8'b1011, 4, 1, 2);
    cyc(0, 1, 0, 0, 0);
    stream(16'b1011011, 7, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Gapped input
    setcfg(8'b1011, 4, 0, 1);
    cyc(0, 1, 0, 0, 0);
    stream(16'b1011, 4, 1);
    cyc(0, 0, 0, 0, 0);

    // Illegal configs
    setcfg(8'b1011, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    setcfg(8'b1011, 4, 0, 0);
    cyc(0, 1, 0, 0, 0);
    setcfg(8'b1011, 12, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Abort on a completing bit; config changes mid-run must not matter
    setcfg(8'b101, 3, 1, 5);
    cyc(0, 1, 0, 0, 0);
    setcfg(8'b11, 2, 0, 1);
    stream(16'b10101, 5, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);

    // Reset mid-session with hit_count=3, then a fresh start
    setcfg(8'b1, 1, 1, 10);
    cyc(0, 1, 0, 0, 0);
    stream(16'b111, 3, 0);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0);
    stream(16'b11, 2, 0);
    setcfg(8'hA5, 8, 1, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    stream(16'h00A5, 8, 0);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0 || bus.start) begin
        r = $urandom_range(0, 19);
        bus.cfg_len = (r == 0) ? LEN_W'(0) :
                      (r == 1) ? LEN_W'($urandom_range(9, 15)) :
                      (r < 6)  ? LEN_W'($urandom_range(5, 8)) : LEN_W'($urandom_range(1, 4));
        bus.cfg_pattern = MAX_LEN'($urandom);
        bus.cfg_overlap = 1'($urandom);
        bus.cfg_target  = ($urandom_range(0, 19) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 4));
      end
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), 1'($urandom));
    end
    cyc(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
